// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and fetch sequencer feeding the instruction register
module instruction_fetch_unit #(
   parameter int                ADDR_W   = 12,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                MAX_WAIT = 15
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              fetch_en,
   input  logic              next_fetch,
   input  logic              stall,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_value,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [15:0]       mem_data,
   output logic [15:0]       instruction,
   output logic              ir_write,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              fetch_err
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_LOAD, S_HOLD} state_t;

   state_t            state;
   logic [CNT_W-1:0]  wait_cnt;
   logic [ADDR_W-1:0] next_pc;

   // A load coinciding with the request edge must steer the new request address.
   assign next_pc = pc_load ? pc_load_value : pc;
   assign busy    = (state == S_REQ) || (state == S_WAIT) || (state == S_LOAD);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         instruction <= '0;
         ir_write    <= 1'b0;
         fetch_err   <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         ir_write <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pc_load) begin
                  pc        <= pc_load_value;
                  fetch_err <= 1'b0;
               end
               if (fetch_en && !fetch_err) begin
                  state    <= S_REQ;
                  mem_req  <= 1'b1;
                  mem_addr <= next_pc;
                  wait_cnt <= '0;
               end
            end
            S_REQ, S_WAIT: begin
               // pc_load and fetch_en are deliberately ignored while a request is in flight.
               if (mem_ready) begin
                  state       <= S_LOAD;
                  mem_req     <= 1'b0;
                  instruction <= mem_data;
                  ir_write    <= 1'b1;
               end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                  state     <= S_IDLE;
                  mem_req   <= 1'b0;
                  fetch_err <= 1'b1;
               end else begin
                  state    <= S_WAIT;
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_LOAD: begin
               pc    <= pc_load ? pc_load_value : pc + 1'b1;
               state <= S_HOLD;
               if (pc_load) fetch_err <= 1'b0;
            end
            S_HOLD: begin
               if (pc_load) begin
                  pc        <= pc_load_value;
                  fetch_err <= 1'b0;
               end
               if (!fetch_en) begin
                  state <= S_IDLE;
               end else if (next_fetch && !stall) begin
                  state    <= S_REQ;
                  mem_req  <= 1'b1;
                  mem_addr <= next_pc;
                  wait_cnt <= '0;
               end
            end
            default: begin
               state   <= S_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        fetch_en, next_fetch, stall, pc_load;
   logic [11:0] pc_load_value;
   logic        mem_req;
   logic [11:0] mem_addr;
   logic        mem_ready;
   logic [15:0] mem_data;
   logic [15:0] instruction;
   logic        ir_write;
   logic [11:0] pc;
   logic        busy;
   logic        fetch_err;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   instruction_fetch_unit #(.ADDR_W(12), .RESET_PC(12'h000), .MAX_WAIT(15)) dut (
      .CLK(CLK), .RST(RST), .fetch_en(fetch_en), .next_fetch(next_fetch), .stall(stall),
      .pc_load(pc_load), .pc_load_value(pc_load_value), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ready(mem_ready), .mem_data(mem_data), .instruction(instruction), .ir_write(ir_write),
      .pc(pc), .busy(busy), .fetch_err(fetch_err)
   );

   task automatic test_reset();
      RST = 1'b0; fetch_en = 0; next_fetch = 0; stall = 0; pc_load = 0;
      pc_load_value = '0; mem_ready = 0; mem_data = '0;
      @(negedge CLK); @(negedge CLK);
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
      total++; if (pc !== 12'h000) begin bad++; $display("FAIL reset_pc got=%h want=000", pc); end
      total++; if (instruction !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h want=0000", instruction); end
      total++; if ({ir_write, busy, fetch_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {ir_write, busy, fetch_err}); end
      total++; if (mem_addr !== 12'h000) begin bad++; $display("FAIL reset_addr got=%h want=000", mem_addr); end
      RST = 1'b1;
   endtask

   task automatic test_zero_wait();
      fetch_en = 1; mem_ready = 1; mem_data = 16'hA5C3;
      @(negedge CLK);
      total++; if ({mem_req, busy, ir_write} !== 3'b110) begin bad++; $display("FAIL zw_req got=%b want=110", {mem_req, busy, ir_write}); end
      total++; if (mem_addr !== 12'h000) begin bad++; $display("FAIL zw_addr got=%h want=000", mem_addr); end
      @(negedge CLK);
      total++; if ({ir_write, mem_req} !== 2'b10) begin bad++; $display("FAIL zw_load got=%b want=10", {ir_write, mem_req}); end
      total++; if (instruction !== 16'hA5C3) begin bad++; $display("FAIL zw_instr got=%h want=a5c3", instruction); end
      mem_ready = 0;
      @(negedge CLK);
      total++; if ({ir_write, busy} !== 2'b00) begin bad++; $display("FAIL zw_hold got=%b want=00", {ir_write, busy}); end
      total++; if (pc !== 12'h001) begin bad++; $display("FAIL zw_pc got=%h want=001", pc); end
      total++; if (instruction !== 16'hA5C3) begin bad++; $display("FAIL zw_instr_held got=%h want=a5c3", instruction); end
   endtask

   task automatic test_wait_states();
      int req_cycles = 0;
      int pulses = 0;
      bit addr_ok = 1;
      next_fetch = 1; mem_data = 16'h1234; mem_ready = 0;
      @(negedge CLK);
      next_fetch = 0;
      for (int k = 0; k < 8; k++) begin
         mem_ready = 0;
         if (mem_req) begin
            req_cycles++;
            if (mem_addr !== 12'h001) addr_ok = 0;
            if (req_cycles == 4) mem_ready = 1;
         end
         if (ir_write) pulses++;
         @(negedge CLK);
      end
      total++; if (req_cycles != 4) begin bad++; $display("FAIL ws_req_cycles got=%0d want=4", req_cycles); end
      total++; if (!addr_ok) begin bad++; $display("FAIL ws_addr_stable got=unstable want=stable 001"); end
      total++; if (pulses != 1) begin bad++; $display("FAIL ws_pulses got=%0d want=1", pulses); end
      total++; if (instruction !== 16'h1234) begin bad++; $display("FAIL ws_instr got=%h want=1234", instruction); end
      total++; if (pc !== 12'h002) begin bad++; $display("FAIL ws_pc got=%h want=002", pc); end
   endtask

   task automatic test_wrap();
      pc_load = 1; pc_load_value = 12'hFFF;
      @(negedge CLK);
      pc_load = 0;
      total++; if (pc !== 12'hFFF) begin bad++; $display("FAIL wrap_load got=%h want=fff", pc); end
      next_fetch = 1; mem_ready = 1; mem_data = 16'hBEEF;
      @(negedge CLK);
      next_fetch = 0;
      total++; if ({mem_req, mem_addr} !== {1'b1, 12'hFFF}) begin bad++; $display("FAIL wrap_addr got=%b/%h want=1/fff", mem_req, mem_addr); end
      @(negedge CLK); @(negedge CLK);
      mem_ready = 0;
      total++; if (pc !== 12'h000) begin bad++; $display("FAIL wrap_pc got=%h want=000", pc); end
      total++; if (instruction !== 16'hBEEF) begin bad++; $display("FAIL wrap_instr got=%h want=beef", instruction); end
   endtask

   task automatic test_branch_in_load();
      next_fetch = 1; mem_ready = 1; mem_data = 16'h7777;
      @(negedge CLK);
      next_fetch = 0;
      @(negedge CLK);
      total++; if (ir_write !== 1'b1) begin bad++; $display("FAIL br_in_load got=%b want=1", ir_write); end
      pc_load = 1; pc_load_value = 12'h040;
      @(negedge CLK);
      pc_load = 0;
      total++; if (pc !== 12'h040) begin bad++; $display("FAIL br_pc got=%h want=040", pc); end
      next_fetch = 1;
      @(negedge CLK);
      next_fetch = 0;
      total++; if ({mem_req, mem_addr} !== {1'b1, 12'h040}) begin bad++; $display("FAIL br_addr got=%b/%h want=1/040", mem_req, mem_addr); end
      @(negedge CLK); @(negedge CLK);
      total++; if (pc !== 12'h041) begin bad++; $display("FAIL br_pc_inc got=%h want=041", pc); end
   endtask

   task automatic test_back_to_back_load();
      next_fetch = 1; pc_load = 1; pc_load_value = 12'h123;
      @(negedge CLK);
      next_fetch = 0; pc_load = 0;
      total++; if ({mem_req, mem_addr, pc} !== {1'b1, 12'h123, 12'h123}) begin bad++; $display("FAIL sim_load got=%b/%h/%h want=1/123/123", mem_req, mem_addr, pc); end
      @(negedge CLK); @(negedge CLK);
      mem_ready = 0;
      total++; if (pc !== 12'h124) begin bad++; $display("FAIL sim_pc got=%h want=124", pc); end
   endtask

   task automatic test_timeout();
      int req_cycles = 0;
      next_fetch = 1; mem_ready = 0;
      @(negedge CLK);
      next_fetch = 0;
      for (int k = 0; k < 20; k++) begin
         if (mem_req) req_cycles++;
         @(negedge CLK);
      end
      total++; if (req_cycles != 15) begin bad++; $display("FAIL to_req_cycles got=%0d want=15", req_cycles); end
      total++; if ({fetch_err, mem_req, busy} !== 3'b100) begin bad++; $display("FAIL to_flags got=%b want=100", {fetch_err, mem_req, busy}); end
      pc_load = 1; pc_load_value = 12'h200;
      @(negedge CLK);
      pc_load = 0;
      total++; if ({fetch_err, mem_req, pc} !== {2'b00, 12'h200}) begin bad++; $display("FAIL to_clear got=%b/%b/%h want=0/0/200", fetch_err, mem_req, pc); end
      @(negedge CLK);
      total++; if ({mem_req, mem_addr} !== {1'b1, 12'h200}) begin bad++; $display("FAIL to_restart got=%b/%h want=1/200", mem_req, mem_addr); end
   endtask

   task automatic test_reset_mid_wait();
      @(negedge CLK);
      total++; if ({mem_req, busy} !== 2'b11) begin bad++; $display("FAIL rst_pre got=%b want=11", {mem_req, busy}); end
      #2 RST = 1'b0;
      #1;
      total++; if ({mem_req, busy, ir_write, fetch_err} !== 4'b0000) begin bad++; $display("FAIL rst_async_flags got=%b want=0000", {mem_req, busy, ir_write, fetch_err}); end
      total++; if ({pc, mem_addr, instruction} !== {12'h000, 12'h000, 16'h0000}) begin bad++; $display("FAIL rst_async_vals got=%h/%h/%h want=000/000/0000", pc, mem_addr, instruction); end
      @(negedge CLK);
      RST = 1'b1;
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_wrap();
      test_branch_in_load();
      test_back_to_back_load();
      test_timeout();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
